// File: rtl/ui_render_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ui_render_pkg
// Description : Types, constants and small helpers shared by the dice
//               controller and its LFSR.
//                 dice_state_t  - controller FSM state encoding
//                 TILE_LAST     - final board tile (reaching it ends the game)
//                 LFSR_POLY     - feedback tap mask for x^8+x^6+x^5+x^4+1
// Revision    : 1.0 - initial release
// ============================================================================
package ui_render_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ROLLING   = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    OVER      = 3'd4
  } dice_state_t;

  localparam logic [3:0] TILE_LAST = 4'd9;

  // Taps at bit positions 7,5,4,3 of a shift-left register, i.e. the
  // polynomial terms x^8, x^6, x^5 and x^4.
  localparam logic [7:0] LFSR_POLY = 8'hB8;

  // One Fibonacci step: shift left, new LSB is the XOR of the tapped bits.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_POLY)};
  endfunction

  // Map an LFSR state onto a die face 1..3.
  function automatic logic [1:0] lfsr_face(input logic [7:0] s);
    return 2'(s % 8'd3) + 2'd1;
  endfunction

  // Face 1..3 to {move_3, move_2, move_1}; anything else gives no command.
  function automatic logic [2:0] face_onehot(input logic [1:0] f);
    logic [2:0] oh;
    case (f)
      2'd1:    oh = 3'b001;
      2'd2:    oh = 3'b010;
      2'd3:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dice_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : dice_lfsr
// Description : Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1).
//               Advances on every clock; never holds zero.
// Ports       : clk     - clock
//               rst     - asynchronous active-high reset (loads SEED)
//               state_o - current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module dice_lfsr
  import ui_render_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] state_o
);

  // A zero seed would lock the register at zero forever; fall back to 1.
  localparam logic [7:0] SAFE_SEED = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] state_q;
  logic [7:0] state_d;

  always_comb begin
    state_d = lfsr_next(state_q);
    // Only reachable if the register was upset; recover instead of locking.
    if (state_q == 8'h00) begin
      state_d = SAFE_SEED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SAFE_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/dice_controller.sv
`default_nettype none
// ============================================================================
// Module      : dice_controller
// Description : Board-game dice controller. A rising edge on btn_roll in
//               IDLE starts a rolling animation; the final face is drawn
//               from an LFSR and issued as one step command (move_1/2/3)
//               to the player controller, which must acknowledge by raising
//               is_moving. Completed moves are counted; landing on the last
//               tile ends the game until reset.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               btn_roll      - debounced roll request (level)
//               is_moving     - player controller busy moving/jumping
//               current_tile  - player's tile, 0..9
//               move_1/2/3    - step commands (one-hot or all low)
//               dice_value    - displayed face, 0 before first roll
//               rolling       - high during the rolling animation
//               busy          - high outside IDLE and OVER
//               game_over     - sticky, player reached the last tile
//               move_fail     - one-cycle pulse on command timeout
//               turn_count    - completed turns, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module dice_controller
  import ui_render_pkg::*;
#(
  parameter int         ROLL_CYCLES = 48,
  parameter int         SPIN_DIV    = 4,
  parameter int         ACK_TIMEOUT = 8,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_roll,
  input  logic       is_moving,
  input  logic [3:0] current_tile,
  output logic       move_1,
  output logic       move_2,
  output logic       move_3,
  output logic [1:0] dice_value,
  output logic       rolling,
  output logic       busy,
  output logic       game_over,
  output logic       move_fail,
  output logic [7:0] turn_count
);

  localparam int ROLL_W = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
  localparam int SPIN_W = (SPIN_DIV    > 1) ? $clog2(SPIN_DIV)    : 1;
  localparam int ACK_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [ROLL_W-1:0] ROLL_LAST = ROLL_W'(ROLL_CYCLES - 1);
  localparam logic [SPIN_W-1:0] SPIN_LAST = SPIN_W'(SPIN_DIV - 1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);

  dice_state_t       state_q, state_d;
  logic [ROLL_W-1:0] roll_cnt_q, roll_cnt_d;
  logic [SPIN_W-1:0] spin_cnt_q, spin_cnt_d;
  logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic              btn_q;
  logic [1:0]        dice_q, dice_d;
  logic [2:0]        move_q, move_d;
  logic              rolling_q, rolling_d;
  logic              busy_q, busy_d;
  logic              game_over_q, game_over_d;
  logic              move_fail_q, move_fail_d;
  logic [7:0]        turn_q, turn_d;

  logic [7:0]        lfsr_state;
  logic              btn_rise;

  dice_lfsr #(
    .SEED    (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .state_o (lfsr_state)
  );

  // History only; whether an edge matters is decided by the FSM, so edges
  // seen outside IDLE are simply dropped rather than remembered.
  assign btn_rise = btn_roll & ~btn_q;

  always_comb begin
    state_d     = state_q;
    roll_cnt_d  = roll_cnt_q;
    spin_cnt_d  = spin_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    dice_d      = dice_q;
    turn_d      = turn_q;
    move_fail_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (btn_rise && !is_moving) begin
          state_d    = ROLLING;
          roll_cnt_d = '0;
          spin_cnt_d = '0;
          dice_d     = 2'd1;
        end
      end

      ROLLING: begin
        if (roll_cnt_q == ROLL_LAST) begin
          dice_d    = lfsr_face(lfsr_state);
          ack_cnt_d = '0;
          state_d   = ISSUE;
        end else begin
          roll_cnt_d = roll_cnt_q + 1'b1;
          if (spin_cnt_q == SPIN_LAST) begin
            spin_cnt_d = '0;
            dice_d     = (dice_q == 2'd3) ? 2'd1 : dice_q + 2'd1;
          end else begin
            spin_cnt_d = spin_cnt_q + 1'b1;
          end
        end
      end

      ISSUE: begin
        // An acknowledge on the last allowed cycle still wins over timeout.
        if (is_moving) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt_q == ACK_LAST) begin
          move_fail_d = 1'b1;
          state_d     = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (!is_moving) begin
          if (turn_q != 8'hFF) begin
            turn_d = turn_q + 8'd1;
          end
          state_d = (current_tile == TILE_LAST) ? OVER : IDLE;
        end
      end

      OVER: begin
        state_d = OVER;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with the
    // state register instead of lagging it by a cycle.
    move_d      = (state_d == ISSUE) ? face_onehot(dice_d) : 3'b000;
    rolling_d   = (state_d == ROLLING);
    busy_d      = (state_d != IDLE) && (state_d != OVER);
    game_over_d = game_over_q | (state_d == OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      roll_cnt_q  <= '0;
      spin_cnt_q  <= '0;
      ack_cnt_q   <= '0;
      btn_q       <= 1'b0;
      dice_q      <= 2'd0;
      move_q      <= 3'b000;
      rolling_q   <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      move_fail_q <= 1'b0;
      turn_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      roll_cnt_q  <= roll_cnt_d;
      spin_cnt_q  <= spin_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      btn_q       <= btn_roll;
      dice_q      <= dice_d;
      move_q      <= move_d;
      rolling_q   <= rolling_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
      move_fail_q <= move_fail_d;
      turn_q      <= turn_d;
    end
  end

  assign move_1     = move_q[0];
  assign move_2     = move_q[1];
  assign move_3     = move_q[2];
  assign dice_value = dice_q;
  assign rolling    = rolling_q;
  assign busy       = busy_q;
  assign game_over  = game_over_q;
  assign move_fail  = move_fail_q;
  assign turn_count = turn_q;

endmodule
`default_nettype wire
